// File: rtl/set_bit_iterator_if.sv
// Handshake bundle for set_bit_iterator: vector load side and per-bit beat side.
// ord_o exists only when SETBIT_ORDINAL_EN is defined.
interface set_bit_iterator_if #(
    parameter int WIDTH = 12
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] vec_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] bit_o;
    logic [IDX_W-1:0] idx_o;
    logic             last_o;
    logic             done_o;

`ifdef SETBIT_ORDINAL_EN
    localparam int ORD_W = $clog2(WIDTH + 1);
    logic [ORD_W-1:0] ord_o;

    modport master (
        output in_valid_i, vec_i, out_ready_i,
        input  in_ready_o, out_valid_o, bit_o, idx_o, last_o, done_o, ord_o
    );
    modport slave (
        input  in_valid_i, vec_i, out_ready_i,
        output in_ready_o, out_valid_o, bit_o, idx_o, last_o, done_o, ord_o
    );
`else
    modport master (
        output in_valid_i, vec_i, out_ready_i,
        input  in_ready_o, out_valid_o, bit_o, idx_o, last_o, done_o
    );
    modport slave (
        input  in_valid_i, vec_i, out_ready_i,
        output in_ready_o, out_valid_o, bit_o, idx_o, last_o, done_o
    );
`endif
endinterface

// File: rtl/set_bit_iterator.sv
// Loads a vector, then emits one beat (one-hot mask + index) per set bit, LSB-first.
// Defining SETBIT_ORDINAL_EN adds an ord_o beat counter.
module set_bit_iterator #(
    parameter int WIDTH = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    set_bit_iterator_if.slave   io
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] low_d;
    logic [WIDTH-1:0] bit_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             ready_q;
    logic             valid_q;
    logic             accept;
    logic             xfer;

`ifdef SETBIT_ORDINAL_EN
    localparam int ORD_W = $clog2(WIDTH + 1);
    logic [ORD_W-1:0] ord_q, ord_d;
`endif

    // ready_q is only ever set while idle, so it doubles as the IDLE qualifier
    assign accept = ready_q & io.in_valid_i;
    assign xfer   = valid_q & io.out_ready_i;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (accept) begin
            if (io.vec_i != '0) begin
                state_d = EMIT;
                rem_d   = io.vec_i;
            end else begin
                done_d = 1'b1;
            end
        end else if (xfer) begin
            rem_d = rem_q & ~bit_q;
            if (last_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Beat outputs are precomputed from the next remainder so they can be registered
        low_d = rem_d & (~rem_d + WIDTH'(1));
        idx_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (low_d[i]) idx_d = IDX_W'(i);
        end
        last_d = ((rem_d & ~low_d) == '0);
    end

`ifdef SETBIT_ORDINAL_EN
    always_comb begin
        ord_d = ord_q;
        if (accept)    ord_d = '0;
        else if (xfer) ord_d = ord_q + ORD_W'(1);
        if (state_d != EMIT) ord_d = '0;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            bit_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
`ifdef SETBIT_ORDINAL_EN
            ord_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            ready_q <= (state_d == IDLE);
            valid_q <= (state_d == EMIT);
            if (state_d == EMIT) begin
                bit_q  <= low_d;
                idx_q  <= idx_d;
                last_q <= last_d;
            end else begin
                bit_q  <= '0;
                idx_q  <= '0;
                last_q <= 1'b0;
            end
`ifdef SETBIT_ORDINAL_EN
            ord_q   <= ord_d;
`endif
        end
    end

    assign io.in_ready_o  = ready_q;
    assign io.out_valid_o = valid_q;
    assign io.bit_o       = bit_q;
    assign io.idx_o       = idx_q;
    assign io.last_o      = last_q;
    assign io.done_o      = done_q;
`ifdef SETBIT_ORDINAL_EN
    assign io.ord_o       = ord_q;
`endif
endmodule

// File: tb/tb_set_bit_iterator.sv
// Self-checking bench for set_bit_iterator: directed scenarios plus randomized vectors
// checked against a queue-of-indices model. Ordinal checks compile in with SETBIT_ORDINAL_EN.
module tb_set_bit_iterator;
    localparam int WIDTH = 12;
    localparam int IDX_W = $clog2(WIDTH);

    logic clk_i = 1'b0;
    logic rst_i;

    int total = 0;
    int bad   = 0;

    // Reference model: positions of the still-pending set bits, lowest first
    int expQ[$];
    int loadedCount;

    set_bit_iterator_if #(.WIDTH(WIDTH)) bus ();

    set_bit_iterator #(.WIDTH(WIDTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .io    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_load(input logic [WIDTH-1:0] v);
        expQ.delete();
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) expQ.push_back(i);
        end
        loadedCount = expQ.size();
    endtask

    // Presents v at the next posedge; returns on the negedge after acceptance
    task automatic send_vector(input logic [WIDTH-1:0] v);
        int waitCycles = 0;
        while (!bus.in_ready_o && waitCycles < 100) begin
            @(negedge clk_i);
            waitCycles++;
        end
        if (!bus.in_ready_o) begin
            total++;
            bad++;
            $display("[TB] FAIL send_ready_timeout in_ready=%0b required=1", bus.in_ready_o);
        end
        bus.in_valid_i = 1'b1;
        bus.vec_i      = v;
        @(negedge clk_i);
        bus.in_valid_i = 1'b0;
        bus.vec_i      = '0;
        model_load(v);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total++;
        if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.done_o !== 1'b0 ||
            bus.bit_o !== '0 || bus.idx_o !== '0 || bus.last_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs rdy=%0b vld=%0b done=%0b bit=%h idx=%0d last=%0b required all 0",
                     bus.in_ready_o, bus.out_valid_o, bus.done_o, bus.bit_o, bus.idx_o, bus.last_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (bus.in_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_release_ready got=%0b required=1", bus.in_ready_o);
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] expBits[3] = '{12'h004, 12'h008, 12'h020};
        int               expIdx[3]  = '{2, 3, 5};
        logic             expLast[3] = '{1'b0, 1'b0, 1'b1};
        bus.out_ready_i = 1'b1;
        send_vector(12'h02C);
        for (int b = 0; b < 3; b++) begin
            total++;
            if (bus.out_valid_o !== 1'b1 || bus.bit_o !== expBits[b] || bus.idx_o !== IDX_W'(expIdx[b]) ||
                bus.last_o !== expLast[b] || bus.done_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL basic_beat%0d got vld=%0b bit=%h idx=%0d last=%0b done=%0b required 1/%h/%0d/%0b/0",
                         b, bus.out_valid_o, bus.bit_o, bus.idx_o, bus.last_o, bus.done_o,
                         expBits[b], expIdx[b], expLast[b]);
            end
            @(negedge clk_i);
        end
        total++;
        if (bus.done_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_done got done=%0b vld=%0b rdy=%0b required 1/0/1",
                     bus.done_o, bus.out_valid_o, bus.in_ready_o);
        end
        @(negedge clk_i);
        total++;
        if (bus.done_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_done_pulse got=%0b required=0", bus.done_o);
        end
    endtask

    task automatic test_zero();
        bus.out_ready_i = 1'b1;
        send_vector(12'h000);
        total++;
        if (bus.done_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL zero_done got done=%0b vld=%0b rdy=%0b required 1/0/1",
                     bus.done_o, bus.out_valid_o, bus.in_ready_o);
        end
        @(negedge clk_i);
        total++;
        if (bus.done_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL zero_after got done=%0b vld=%0b rdy=%0b required 0/0/1",
                     bus.done_o, bus.out_valid_o, bus.in_ready_o);
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        bus.out_ready_i = 1'b1;
        send_vector(12'h02C);
        beats++;
        @(negedge clk_i);
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (bus.out_valid_o !== 1'b1 || bus.bit_o !== 12'h008 || bus.idx_o !== IDX_W'(3) || bus.last_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d got vld=%0b bit=%h idx=%0d last=%0b required 1/008/3/0",
                         c, bus.out_valid_o, bus.bit_o, bus.idx_o, bus.last_o);
            end
            @(negedge clk_i);
        end
        bus.out_ready_i = 1'b1;
        beats++;
        @(negedge clk_i);
        total++;
        if (bus.out_valid_o !== 1'b1 || bus.bit_o !== 12'h020 || bus.idx_o !== IDX_W'(5) || bus.last_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_last got vld=%0b bit=%h idx=%0d last=%0b required 1/020/5/1",
                     bus.out_valid_o, bus.bit_o, bus.idx_o, bus.last_o);
        end
        beats++;
        @(negedge clk_i);
        total++;
        if (bus.out_valid_o !== 1'b0 || bus.done_o !== 1'b1 || beats != 3) begin
            bad++;
            $display("[TB] FAIL stall_end got vld=%0b done=%0b beats=%0d required 0/1/3",
                     bus.out_valid_o, bus.done_o, beats);
        end
    endtask

    task automatic test_full();
        bus.out_ready_i = 1'b1;
        send_vector(12'hFFF);
        for (int i = 0; i < WIDTH; i++) begin
            total++;
            if (bus.out_valid_o !== 1'b1 || bus.idx_o !== IDX_W'(i) || bus.bit_o !== (WIDTH'(1) << i) ||
                bus.last_o !== (i == WIDTH - 1) || bus.in_ready_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL full_beat%0d got vld=%0b idx=%0d bit=%h last=%0b rdy=%0b required 1/%0d/%h/%0b/0",
                         i, bus.out_valid_o, bus.idx_o, bus.bit_o, bus.last_o, bus.in_ready_o,
                         i, WIDTH'(1) << i, i == WIDTH - 1);
            end
            bus.in_valid_i = (i == 5);
            bus.vec_i      = (i == 5) ? 12'h001 : 12'h000;
            @(negedge clk_i);
        end
        bus.in_valid_i = 1'b0;
        total++;
        if (bus.out_valid_o !== 1'b0 || bus.done_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_end got vld=%0b done=%0b required 0/1", bus.out_valid_o, bus.done_o);
        end
        @(negedge clk_i);
        total++;
        if (bus.out_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_no_extra got vld=%0b required=0", bus.out_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready_i = 1'b1;
        send_vector(12'h0F0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        total++;
        if (bus.out_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_outputs got vld=%0b done=%0b rdy=%0b required 0/0/0",
                     bus.out_valid_o, bus.done_o, bus.in_ready_o);
        end
        @(negedge clk_i);
        total++;
        if (bus.out_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_idle got vld=%0b done=%0b rdy=%0b required 0/0/1",
                     bus.out_valid_o, bus.done_o, bus.in_ready_o);
        end
        send_vector(12'h800);
        total++;
        if (bus.out_valid_o !== 1'b1 || bus.bit_o !== 12'h800 || bus.idx_o !== IDX_W'(11) || bus.last_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_msb got vld=%0b bit=%h idx=%0d last=%0b required 1/800/11/1",
                     bus.out_valid_o, bus.bit_o, bus.idx_o, bus.last_o);
        end
        @(negedge clk_i);
        total++;
        if (bus.done_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_done got done=%0b vld=%0b required 1/0", bus.done_o, bus.out_valid_o);
        end
    endtask

`ifdef SETBIT_ORDINAL_EN
    task automatic test_ordinal();
        bus.out_ready_i = 1'b1;
        send_vector(12'h801);
        total++;
        if (bus.idx_o !== IDX_W'(0) || bus.ord_o !== '0 || bus.last_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ord_beat0 got idx=%0d ord=%0d last=%0b required 0/0/0",
                     bus.idx_o, bus.ord_o, bus.last_o);
        end
        @(negedge clk_i);
        total++;
        if (bus.idx_o !== IDX_W'(11) || bus.ord_o !== 1 || bus.last_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ord_beat1 got idx=%0d ord=%0d last=%0b required 11/1/1",
                     bus.idx_o, bus.ord_o, bus.last_o);
        end
        @(negedge clk_i);
        total++;
        if (bus.ord_o !== '0) begin
            bad++;
            $display("[TB] FAIL ord_idle got=%0d required=0", bus.ord_o);
        end
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] expBit;
        logic             rdy;
        int               cyc;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(9))
                0:       v = '0;
                1:       v = WIDTH'(1) << $urandom_range(WIDTH - 1);
                default: v = WIDTH'($urandom);
            endcase
            bus.out_ready_i = 1'b0;
            send_vector(v);
            if (v == '0) begin
                total++;
                if (bus.done_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL rand_zero vec=%h got done=%0b vld=%0b required 1/0",
                             v, bus.done_o, bus.out_valid_o);
                end
                continue;
            end
            cyc = 0;
            while (expQ.size() > 0 && cyc < 200) begin
                expBit = '0;
                expBit[expQ[0]] = 1'b1;
                total++;
                if (bus.out_valid_o !== 1'b1 || bus.bit_o !== expBit || bus.idx_o !== IDX_W'(expQ[0]) ||
                    bus.last_o !== (expQ.size() == 1) || bus.in_ready_o !== 1'b0 || bus.done_o !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL rand_beat vec=%h got vld=%0b bit=%h idx=%0d last=%0b rdy=%0b done=%0b required 1/%h/%0d/%0b/0/0",
                             v, bus.out_valid_o, bus.bit_o, bus.idx_o, bus.last_o, bus.in_ready_o, bus.done_o,
                             expBit, expQ[0], expQ.size() == 1);
                end
`ifdef SETBIT_ORDINAL_EN
                total++;
                if (bus.ord_o !== (loadedCount - expQ.size())) begin
                    bad++;
                    $display("[TB] FAIL rand_ord vec=%h got=%0d required=%0d",
                             v, bus.ord_o, loadedCount - expQ.size());
                end
`endif
                rdy = ($urandom_range(99) < 65);
                bus.out_ready_i = rdy;
                if (rdy) void'(expQ.pop_front());
                @(negedge clk_i);
                cyc++;
            end
            bus.out_ready_i = 1'b0;
            total++;
            if (expQ.size() != 0 || bus.done_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL rand_end vec=%h left=%0d got done=%0b vld=%0b rdy=%0b required 0/1/0/1",
                         v, expQ.size(), bus.done_o, bus.out_valid_o, bus.in_ready_o);
            end
        end
    endtask

    initial begin
        rst_i           = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.vec_i       = '0;
        bus.out_ready_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_full();
        test_reset_mid();
`ifdef SETBIT_ORDINAL_EN
        test_ordinal();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
